update_debouncer: RTL and testbench

Input conditioning stage that sits directly upstream of the `dcm` clock generator. It synchronises the raw `update` push-button and the 3-bit frequency-select switches to `clk`, and debounces the button with a counter-based state machine. For each clean press it emits exactly one single-cycle `update` pulse, together with a `prog_in` value that is held stable and was itself stable for the whole debounce window. Both outputs connect directly to the `update` and `prog_in` inputs of `dcm`.

---
 rtl/update_debouncer.sv | 128 ++++++++++++
 tb/tb_update_debouncer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/update_debouncer.sv
// Synchronises the update button and frequency-select switches, debounces the button,
// and issues one update pulse per clean press with the switch value stable over the window.
module update_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned CNT_W           = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [2:0] sw_raw,
    output logic       update,
    output logic [2:0] prog_in,
    output logic       btn_level
);

    localparam int unsigned SW_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic            btn_meta;
    logic            btn_s;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_s;

    state_t          state;
    state_t          state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [SW_W-1:0] sw_hold;
    logic [SW_W-1:0] sw_hold_nx;
    logic            update_nx;
    logic [SW_W-1:0] prog_in_nx;
    logic            btn_level_nx;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            sw_meta  <= '0;
            sw_s     <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
            sw_meta  <= sw_raw;
            sw_s     <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sw_hold   <= '0;
            update    <= 1'b0;
            prog_in   <= '0;
            btn_level <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sw_hold   <= sw_hold_nx;
            update    <= update_nx;
            prog_in   <= prog_in_nx;
            btn_level <= btn_level_nx;
        end
    end

    // Debounce FSM; a switch change inside the press window restarts it
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        sw_hold_nx = sw_hold;
        update_nx  = 1'b0;
        prog_in_nx = prog_in;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx   = PRESS_WAIT;
                    cnt_nx     = '0;
                    sw_hold_nx = sw_s;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (sw_s != sw_hold) begin
                    cnt_nx     = '0;
                    sw_hold_nx = sw_s;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = PRESSED;
                    update_nx  = 1'b1;
                    prog_in_nx = sw_hold;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nx = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        btn_level_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_update_debouncer.sv
// Bench for update_debouncer: directed table, multi-cycle corner sequences and
// randomized traffic against a run-length reference model.
module tb_update_debouncer;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 3;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       btn_raw = 1'b0;
    logic [2:0] sw_raw  = 3'b000;
    logic       update;
    logic [2:0] prog_in;
    logic       btn_level;

    always #5 clk = ~clk;

    update_debouncer #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .update   (update),
        .prog_in  (prog_in),
        .btn_level(btn_level)
    );

    typedef struct {
        logic       btn;
        logic [2:0] sw;
        logic       upd;
        logic [2:0] prog;
        logic       lvl;
    } vec_t;

    vec_t tbl[16];

    int nvec = 0;
    int nerr = 0;

    // Reference model: synchroniser delay line plus run lengths of stable input
    logic       hb[2];
    logic [2:0] hs[2];
    int         hrun;
    int         lrun;
    logic       pb;
    logic [2:0] ps;
    logic       mlvl;
    logic       mupd;
    logic [2:0] mprog;

    int   tick_no  = 0;
    int   pulses   = 0;
    int   pulse_at = 0;
    int   fall_at  = 0;
    int   rise_at  = 0;
    int   t0       = 0;
    logic prev_lvl = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at tick %0d: got %0d expected %0d", nm, tick_no, act, exp);
        end
    endtask

    task automatic model_reset();
        hb[0] = 1'b0; hb[1] = 1'b0;
        hs[0] = 3'b000; hs[1] = 3'b000;
        hrun = 0; lrun = 0;
        pb = 1'b0; ps = 3'b000;
        mlvl = 1'b0; mupd = 1'b0; mprog = 3'b000;
    endtask

    task automatic tick(input logic b, input logic [2:0] s);
        logic       mb;
        logic [2:0] ms;
        btn_raw = b;
        sw_raw  = s;
        @(posedge clk);
        tick_no++;
        if (!rst) begin
            model_reset();
        end else begin
            mb = hb[1]; ms = hs[1];
            hb[1] = hb[0]; hs[1] = hs[0];
            hb[0] = b;     hs[0] = s;
            if (mb) begin
                hrun = (pb && ms == ps) ? hrun + 1 : 1;
                lrun = 0;
            end else begin
                hrun = 0;
                lrun = lrun + 1;
            end
            mupd = 1'b0;
            // A press is accepted after N+1 edges of high button with unchanged switches
            if (!mlvl && hrun == int'(N) + 1) begin
                mupd  = 1'b1;
                mlvl  = 1'b1;
                mprog = ms;
            end else if (mlvl && lrun == int'(N) + 1) begin
                mlvl = 1'b0;
            end
            pb = mb;
            ps = ms;
        end
        #1;
        chk("update",    int'(update),    int'(mupd));
        chk("prog_in",   int'(prog_in),   int'(mprog));
        chk("btn_level", int'(btn_level), int'(mlvl));
        if (update) begin
            pulses++;
            pulse_at = tick_no;
        end
        if (prev_lvl && !btn_level) fall_at = tick_no;
        prev_lvl = btn_level;
    endtask

    task automatic idle(input int n, input logic [2:0] s);
        for (int i = 0; i < n; i++) tick(1'b0, s);
    endtask

    initial begin
        logic       rb;
        logic [2:0] rs;

        for (int i = 0; i < 16; i++) begin
            tbl[i].btn  = (i < 9);
            tbl[i].sw   = 3'b101;
            tbl[i].upd  = (i == 6);
            tbl[i].prog = (i >= 6) ? 3'b101 : 3'b000;
            tbl[i].lvl  = (i >= 6 && i < 15);
        end

        model_reset();
        #2;
        chk("reset_update",    int'(update),    0);
        chk("reset_prog_in",   int'(prog_in),   0);
        chk("reset_btn_level", int'(btn_level), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Clean press and release from reset
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].btn, tbl[i].sw);
            chk("tbl_update",    int'(update),    int'(tbl[i].upd));
            chk("tbl_prog_in",   int'(prog_in),   int'(tbl[i].prog));
            chk("tbl_btn_level", int'(btn_level), int'(tbl[i].lvl));
        end

        // Bounce on press
        idle(8, 3'b011);
        pulses = 0;
        tick(1'b1, 3'b011); tick(1'b0, 3'b011);
        tick(1'b1, 3'b011); tick(1'b0, 3'b011);
        tick(1'b1, 3'b011);
        rise_at = tick_no;
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b011);
        chk("bounce_pulses", pulses, 1);
        chk("bounce_latency", pulse_at - rise_at, 6);
        idle(12, 3'b011);

        // Short glitch is rejected
        pulses = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 3'b101);
        idle(10, 3'b101);
        chk("glitch_pulses", pulses, 0);
        chk("glitch_prog_in", int'(prog_in), 3);
        chk("glitch_btn_level", int'(btn_level), 0);

        // Switch change inside the window restarts it
        pulses = 0;
        tick(1'b1, 3'b010);
        rise_at = tick_no;
        tick(1'b1, 3'b010); tick(1'b1, 3'b010);
        for (int i = 0; i < 10; i++) tick(1'b1, 3'b111);
        chk("swchg_pulses", pulses, 1);
        chk("swchg_latency", pulse_at - rise_at, 9);
        chk("swchg_prog_in", int'(prog_in), 7);
        idle(12, 3'b111);

        // Long hold with bounce on release
        pulses = 0;
        fall_at = 0;
        for (int i = 0; i < 50; i++) tick(1'b1, 3'b110);
        tick(1'b0, 3'b110); tick(1'b1, 3'b110); tick(1'b0, 3'b110);
        t0 = tick_no;
        idle(12, 3'b110);
        chk("hold_pulses", pulses, 1);
        chk("hold_fall_latency", fall_at - t0, 6);
        chk("hold_prog_in", int'(prog_in), 6);

        // Async reset in the middle of the press window
        pulses = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, 3'b101);
        rst = 1'b0;
        btn_raw = 1'b0;
        #1;
        chk("midrst_update",    int'(update),    0);
        chk("midrst_prog_in",   int'(prog_in),   0);
        chk("midrst_btn_level", int'(btn_level), 0);
        model_reset();
        tick(1'b0, 3'b101); tick(1'b0, 3'b101);
        rst = 1'b1;
        idle(12, 3'b101);
        chk("midrst_pulses", pulses, 0);

        // Randomized traffic with occasional resets
        rb = 1'b0;
        rs = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            if ($urandom_range(0, 24) == 0) rs = 3'($urandom);
            rst = ($urandom_range(0, 499) != 0);
            tick(rb, rs);
        end
        rst = 1'b1;
        idle(12, rs);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
